uart_tx: RTL and testbench

- 8N1 asynchronous serial transmitter: serialises one byte per request onto a single idle-high line.
- Frame format: start bit, 8 data bits LSB first, one stop bit.
- Sits between a byte producer (command/response logic) and the board's UART TX pin.
- Runs off the 12 MHz system clock with an internal baud-rate divider.

---
 rtl/uart_tx_if.sv | 21 ++
 rtl/uart_tx.sv | 125 ++++++++++++
 tb/tb_uart_tx.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Byte-producer to UART transmitter handshake: request/data in, line and busy out.
interface uart_tx_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx;
  logic       tx_busy;

  modport master (
    output tx_start,
    output tx_data,
    input  tx,
    input  tx_busy
  );

  modport slave (
    input  tx_start,
    input  tx_data,
    output tx,
    output tx_busy
  );
endinterface

// File: rtl/uart_tx.sv
// 8N1 serial transmitter: start bit, 8 data bits LSB first, one stop bit.
// Line and busy are driven straight from flops so the pin never glitches.
module uart_tx #(
  parameter int unsigned CLK_FREQ = 12000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic      CLK,
  input  logic      RST_N,
  uart_tx_if.slave  bus
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W        = 3;
  localparam int unsigned DATA_W       = 8;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    baud_q,  baud_d;
  logic [BIT_W-1:0]    bit_q,   bit_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                tx_q,    tx_d;
  logic                busy_q,  busy_d;
  logic                cell_end_c;

  assign cell_end_c = (baud_q == BAUD_LAST);

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state: every non-idle state lasts whole bit cells.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.tx_start)                        state_d = S_START;
      S_START: if (cell_end_c)                          state_d = S_DATA;
      S_DATA:  if (cell_end_c && (bit_q == BIT_LAST))   state_d = S_STOP;
      S_STOP:  if (cell_end_c)                          state_d = S_IDLE;
      default:                                          state_d = S_IDLE;
    endcase
  end

  // Outputs are computed one cycle ahead so the line level lands with the state change.
  always_comb begin
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;

    if (state_q != S_IDLE) begin
      baud_d = cell_end_c ? '0 : baud_q + CNT_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (bus.tx_start) begin
          shift_d = bus.tx_data;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_START: begin
        if (cell_end_c) begin
          bit_d = '0;
          tx_d  = shift_q[0];
        end
      end
      S_DATA: begin
        if (cell_end_c) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            tx_d = 1'b1;
          end else begin
            bit_d = bit_q + BIT_W'(1);
            tx_d  = shift_q[1];
          end
        end
      end
      S_STOP: begin
        if (cell_end_c) begin
          tx_d   = 1'b1;
          busy_d = 1'b0;
        end
      end
      default: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
    endcase
  end

  assign bus.tx      = tx_q;
  assign bus.tx_busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: expected line waveform is built from the 8N1 frame definition.
module tb_uart_tx;

  localparam int CPB   = 12000000 / 115200;
  localparam int FRAME = 10 * CPB;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  uart_tx_if u_if ();

  uart_tx dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (u_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Follows one frame from the cycle after accept; optionally drops the request or changes data mid-frame.
  task automatic check_frame(input logic [7:0] d, input int drop_at, input int chg_at,
                             input logic [7:0] chg_val, input string tag);
    logic [9:0] frame;
    int         hits [10];
    int         busy_hits;
    frame     = {1'b1, d, 1'b0};
    busy_hits = 0;
    for (int c = 0; c < 10; c++) hits[c] = 0;
    n_vec++;
    if ({u_if.tx, u_if.tx_busy} !== 2'b01) begin
      n_err++;
      $display("FAIL %s first cycle: tx,busy=%b%b expected 01", tag, u_if.tx, u_if.tx_busy);
    end
    for (int k = 0; k < FRAME; k++) begin
      if (u_if.tx === frame[k / CPB]) hits[k / CPB]++;
      if (u_if.tx_busy === 1'b1) busy_hits++;
      if (k == drop_at) u_if.tx_start = 1'b0;
      if (k == chg_at)  u_if.tx_data  = chg_val;
      @(negedge clk);
    end
    for (int c = 0; c < 10; c++) begin
      n_vec++;
      if (hits[c] !== CPB) begin
        n_err++;
        $display("FAIL %s cell %0d: %0d cycles at level %0b, expected %0d", tag, c, hits[c],
                 frame[c], CPB);
      end
    end
    n_vec++;
    if (busy_hits !== FRAME) begin
      n_err++;
      $display("FAIL %s busy length: %0d cycles, expected %0d", tag, busy_hits, FRAME);
    end
    n_vec++;
    if ({u_if.tx, u_if.tx_busy} !== 2'b10) begin
      n_err++;
      $display("FAIL %s end of frame: tx,busy=%b%b expected 10", tag, u_if.tx, u_if.tx_busy);
    end
  endtask

  // Checks the line stays idle for n cycles.
  task automatic check_idle(input int n, input string tag);
    int ok;
    ok = 0;
    for (int k = 0; k < n; k++) begin
      if ({u_if.tx, u_if.tx_busy} === 2'b10) ok++;
      @(negedge clk);
    end
    n_vec++;
    if (ok !== n) begin
      n_err++;
      $display("FAIL %s idle: %0d of %0d cycles idle", tag, ok, n);
    end
  endtask

  task automatic start_req(input logic [7:0] d);
    u_if.tx_data  = d;
    u_if.tx_start = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_vec++;
      if ({u_if.tx, u_if.tx_busy} !== 2'b10) begin
        n_err++;
        $display("FAIL reset cycle %0d: tx,busy=%b%b expected 10", k, u_if.tx, u_if.tx_busy);
      end
    end
    u_if.tx_start = 1'b0;
    rst_n         = 1'b1;
    check_idle(3, "post_reset");
  endtask

  task automatic test_single();
    start_req(8'h48);
    check_frame(8'h48, 5, -1, 8'h00, "single_0x48");
    check_idle(20, "single_no_repeat");
  endtask

  task automatic test_back_to_back();
    u_if.tx_data  = 8'h55;
    u_if.tx_start = 1'b1;
    @(negedge clk);
    for (int f = 0; f < 3; f++) begin
      check_frame(8'h55, -1, -1, 8'h00, $sformatf("b2b_%0d", f));
      if (f == 2) u_if.tx_start = 1'b0;
      @(negedge clk);
    end
    check_idle(5, "b2b_after");
  endtask

  task automatic test_data_change();
    start_req(8'hA5);
    check_frame(8'hA5, 0, 300, 8'hFF, "change_0xA5");
    check_idle(2, "change_after");
  endtask

  task automatic test_mid_reset();
    start_req(8'h00);
    u_if.tx_start = 1'b0;
    // Stop inside data bit 3 (cell 4 of the frame).
    repeat (4 * CPB + 40) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({u_if.tx, u_if.tx_busy} !== 2'b10) begin
      n_err++;
      $display("FAIL mid_reset: tx,busy=%b%b expected 10", u_if.tx, u_if.tx_busy);
    end
    rst_n = 1'b1;
    check_idle(4, "mid_reset_after");
    start_req(8'h81);
    check_frame(8'h81, 0, -1, 8'h00, "after_reset_0x81");
    check_idle(2, "after_reset_idle");
  endtask

  task automatic test_boundary();
    start_req(8'h00);
    check_frame(8'h00, 0, -1, 8'h00, "bound_0x00");
    check_idle(2, "bound_gap");
    start_req(8'hFF);
    check_frame(8'hFF, 0, -1, 8'h00, "bound_0xFF");
    check_idle(2, "bound_after");
  endtask

  task automatic test_random();
    logic [7:0] d;
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      check_idle(int'($urandom_range(1, 6)), $sformatf("rand_gap_%0d", i));
      start_req(d);
      check_frame(d, int'($urandom_range(0, 1000)), int'($urandom_range(1, 1030)),
                  8'($urandom), $sformatf("rand_%0d_0x%02h", i, d));
    end
    check_idle(3, "rand_after");
  endtask

  initial begin
    n_vec         = 0;
    n_err         = 0;
    rst_n         = 1'b0;
    u_if.tx_start = 1'b1;
    u_if.tx_data  = 8'h3C;
    test_reset();
    test_single();
    test_back_to_back();
    test_data_change();
    test_mid_reset();
    test_boundary();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
